// File: rtl/clus_pattern_check.sv
// Cluster-stream checker on the ROCFIFO_SIM read side: parses event headers,
// regenerates the expected payload and keeps event/error counters and first-error captures.
module clus_pattern_check #(
  parameter int unsigned DIGI_BITS = 32,
  parameter int unsigned TAG_BITS  = 20,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                 fifoclk,
  input  logic                 fifoclk_reset,
  input  logic                 newspill_reset,
  input  logic                 haltrun_en,
  input  logic                 pattern_type,
  input  logic                 check_en,
  input  logic                 fifo_empty,
  input  logic [DIGI_BITS-1:0] fifo_data,
  output logic                 fifo_re,
  output logic [31:0]          evt_cnt,
  output logic [CNT_BITS-1:0]  word_err_cnt,
  output logic [CNT_BITS-1:0]  tag_err_cnt,
  output logic                 err_sticky,
  output logic [DIGI_BITS-1:0] first_err_got,
  output logic [DIGI_BITS-1:0] first_err_exp,
  output logic [TAG_BITS-1:0]  last_tag,
  output logic                 busy
);

  localparam int unsigned SIZE_LSB  = 20;
  localparam int unsigned SIZE_BITS = 12;
  localparam int unsigned REM_BITS  = 14;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HDR_WAIT  = 3'd1;
  localparam logic [2:0] DATA_REQ  = 3'd2;
  localparam logic [2:0] DATA_WAIT = 3'd3;
  localparam logic [2:0] EMPTY_EVT = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [DIGI_BITS-1:0] ALT_EVEN = {(DIGI_BITS/2){2'b01}};
  localparam logic [DIGI_BITS-1:0] ALT_ODD  = {(DIGI_BITS/2){2'b10}};

  logic [2:0]           state_q, state_d;
  logic [31:0]          exp_cnt_q, exp_cnt_d;
  logic                 alt_idx_q, alt_idx_d;
  logic                 tag_valid_q, tag_valid_d;
  logic                 from_empty_q, from_empty_d;
  logic [REM_BITS-1:0]  rem_cnt_q, rem_cnt_d;
  logic [31:0]          evt_cnt_q, evt_cnt_d;
  logic [CNT_BITS-1:0]  word_err_q, word_err_d;
  logic [CNT_BITS-1:0]  tag_err_q, tag_err_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [DIGI_BITS-1:0] first_got_q, first_got_d;
  logic [DIGI_BITS-1:0] first_exp_q, first_exp_d;
  logic [TAG_BITS-1:0]  last_tag_q, last_tag_d;
  logic                 busy_q, busy_d;

  logic [SIZE_BITS-1:0] hdr_size;
  logic [TAG_BITS-1:0]  hdr_tag;
  logic                 tag_bad;
  logic [DIGI_BITS-1:0] exp_word;

  // Next-state, counters and the combinational read strobe.
  always_comb begin
    state_d      = state_q;
    exp_cnt_d    = exp_cnt_q;
    alt_idx_d    = alt_idx_q;
    tag_valid_d  = tag_valid_q;
    from_empty_d = from_empty_q;
    rem_cnt_d    = rem_cnt_q;
    evt_cnt_d    = evt_cnt_q;
    word_err_d   = word_err_q;
    tag_err_d    = tag_err_q;
    err_sticky_d = err_sticky_q;
    first_got_d  = first_got_q;
    first_exp_d  = first_exp_q;
    last_tag_d   = last_tag_q;
    fifo_re      = 1'b0;

    hdr_size = fifo_data[SIZE_LSB +: SIZE_BITS];
    hdr_tag  = fifo_data[TAG_BITS-1:0];
    tag_bad  = tag_valid_q && (hdr_tag != TAG_BITS'(last_tag_q + TAG_BITS'(1)));
    exp_word = pattern_type ? (alt_idx_q ? ALT_ODD : ALT_EVEN) : DIGI_BITS'(exp_cnt_q);

    if (newspill_reset) begin
      // Re-arm for a new spill; counters and captures survive, in-flight word is dropped.
      state_d      = IDLE;
      alt_idx_d    = 1'b0;
      tag_valid_d  = 1'b0;
      from_empty_d = 1'b0;
      if (!haltrun_en) exp_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (check_en && !fifo_empty) begin
            fifo_re = 1'b1;
            state_d = HDR_WAIT;
          end
        end
        HDR_WAIT: begin
          last_tag_d  = hdr_tag;
          rem_cnt_d   = {hdr_size, 2'b00};
          tag_valid_d = 1'b1;
          if (tag_bad || hdr_size[0]) begin
            if (tag_err_q != '1) tag_err_d = tag_err_q + CNT_BITS'(1);
            err_sticky_d = 1'b1;
          end
          state_d = (hdr_size == '0) ? EMPTY_EVT : DATA_REQ;
        end
        DATA_REQ: begin
          if (!fifo_empty) begin
            fifo_re = 1'b1;
            state_d = DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          if (fifo_data != exp_word) begin
            if (word_err_q != '1) word_err_d = word_err_q + CNT_BITS'(1);
            if (!err_sticky_q) begin
              first_got_d = fifo_data;
              first_exp_d = exp_word;
            end
            err_sticky_d = 1'b1;
          end
          alt_idx_d = ~alt_idx_q;
          rem_cnt_d = rem_cnt_q - REM_BITS'(1);
          if (rem_cnt_q == REM_BITS'(1)) begin
            state_d = DONE;
          end else begin
            exp_cnt_d = exp_cnt_q + 32'd1;
            state_d   = DATA_REQ;
          end
        end
        EMPTY_EVT: begin
          // The writer burns one counter value and one alternating slot on an empty event.
          exp_cnt_d    = exp_cnt_q + 32'd1;
          alt_idx_d    = ~alt_idx_q;
          from_empty_d = 1'b1;
          state_d      = DONE;
        end
        DONE: begin
          if (!from_empty_q) exp_cnt_d = exp_cnt_q + 32'd1;
          from_empty_d = 1'b0;
          evt_cnt_d    = evt_cnt_q + 32'd1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge fifoclk) begin
    if (fifoclk_reset) begin
      state_q      <= IDLE;
      exp_cnt_q    <= '0;
      alt_idx_q    <= 1'b0;
      tag_valid_q  <= 1'b0;
      from_empty_q <= 1'b0;
      rem_cnt_q    <= '0;
      evt_cnt_q    <= '0;
      word_err_q   <= '0;
      tag_err_q    <= '0;
      err_sticky_q <= 1'b0;
      first_got_q  <= '0;
      first_exp_q  <= '0;
      last_tag_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_cnt_q    <= exp_cnt_d;
      alt_idx_q    <= alt_idx_d;
      tag_valid_q  <= tag_valid_d;
      from_empty_q <= from_empty_d;
      rem_cnt_q    <= rem_cnt_d;
      evt_cnt_q    <= evt_cnt_d;
      word_err_q   <= word_err_d;
      tag_err_q    <= tag_err_d;
      err_sticky_q <= err_sticky_d;
      first_got_q  <= first_got_d;
      first_exp_q  <= first_exp_d;
      last_tag_q   <= last_tag_d;
      busy_q       <= busy_d;
    end
  end

  assign evt_cnt       = evt_cnt_q;
  assign word_err_cnt  = word_err_q;
  assign tag_err_cnt   = tag_err_q;
  assign err_sticky    = err_sticky_q;
  assign first_err_got = first_got_q;
  assign first_err_exp = first_exp_q;
  assign last_tag      = last_tag_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_clus_pattern_check.sv
// Directed bench for clus_pattern_check with a queue-backed model of ROCFIFO_SIM.
module tb_clus_pattern_check;

  logic        fifoclk = 1'b0;
  logic        fifoclk_reset = 1'b1;
  logic        newspill_reset = 1'b0;
  logic        haltrun_en = 1'b0;
  logic        pattern_type = 1'b0;
  logic        check_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        fifo_re;
  logic [31:0] evt_cnt;
  logic [15:0] word_err_cnt;
  logic [15:0] tag_err_cnt;
  logic        err_sticky;
  logic [31:0] first_err_got;
  logic [31:0] first_err_exp;
  logic [19:0] last_tag;
  logic        busy;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int re_viol = 0;
  int phase = 0;
  bit stall_mode = 1'b0;
  logic [31:0] q[$];

  clus_pattern_check dut (
    .fifoclk(fifoclk), .fifoclk_reset(fifoclk_reset), .newspill_reset(newspill_reset),
    .haltrun_en(haltrun_en), .pattern_type(pattern_type), .check_en(check_en),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_re(fifo_re),
    .evt_cnt(evt_cnt), .word_err_cnt(word_err_cnt), .tag_err_cnt(tag_err_cnt),
    .err_sticky(err_sticky), .first_err_got(first_err_got), .first_err_exp(first_err_exp),
    .last_tag(last_tag), .busy(busy)
  );

  always #5 fifoclk = ~fifoclk;

  // FIFO model: registered read data, one cycle after the strobe.
  always @(posedge fifoclk) begin
    if (fifo_re === 1'b1) begin
      rd_cnt++;
      if (fifo_empty) re_viol++;
      if (q.size() > 0) fifo_data <= q.pop_front();
      else fifo_data <= 32'hDEAD_BEEF;
    end
  end

  always @(negedge fifoclk) begin
    phase = stall_mode ? (phase + 1) % 3 : 0;
    fifo_empty = (q.size() == 0) || (stall_mode && phase != 0);
  end

  task automatic do_reset();
    @(posedge fifoclk); #2;
    fifoclk_reset = 1'b1; newspill_reset = 1'b0; check_en = 1'b0;
    pattern_type = 1'b0; haltrun_en = 1'b0; stall_mode = 1'b0;
    q.delete();
    repeat (2) @(posedge fifoclk);
    #2;
    fifoclk_reset = 1'b0;
    rd_cnt = 0;
  endtask

  task automatic push_evt(input logic [31:0] hdr, input int first, input int n);
    q.push_back(hdr);
    for (int i = 0; i < n; i++) q.push_back(32'(first + i));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge fifoclk);
      n++;
    end while (!(q.size() == 0 && busy === 1'b0) && n < 3000);
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s timeout q=%0d busy=%b", name, q.size(), busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge fifoclk);
    total++; if (evt_cnt !== 32'd0) begin bad++; $display("FAIL reset evt_cnt got=%0d exp=0", evt_cnt); end
    total++; if (word_err_cnt !== 16'd0) begin bad++; $display("FAIL reset word_err got=%0d exp=0", word_err_cnt); end
    total++; if (tag_err_cnt !== 16'd0) begin bad++; $display("FAIL reset tag_err got=%0d exp=0", tag_err_cnt); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset sticky got=%b exp=0", err_sticky); end
    total++; if (first_err_got !== 32'd0 || first_err_exp !== 32'd0) begin
      bad++; $display("FAIL reset captures got=%h/%h exp=0/0", first_err_got, first_err_exp); end
    total++; if (last_tag !== 20'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset tag/busy got=%h/%b exp=0/0", last_tag, busy); end
    // With check_en low nothing is read even when data is waiting.
    @(posedge fifoclk); #2;
    push_evt(32'h0040_0001, 0, 16);
    repeat (10) @(negedge fifoclk);
    total++; if (rd_cnt !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL check_en_low reads got=%0d busy=%b exp=0/0", rd_cnt, busy); end
  endtask

  task automatic test_single();
    do_reset();
    check_en = 1'b1;
    push_evt(32'h0040_0001, 0, 16);
    wait_done("single");
    total++; if (evt_cnt !== 32'd1) begin bad++; $display("FAIL single evt_cnt got=%0d exp=1", evt_cnt); end
    total++; if (word_err_cnt !== 16'd0) begin bad++; $display("FAIL single word_err got=%0d exp=0", word_err_cnt); end
    total++; if (last_tag !== 20'd1) begin bad++; $display("FAIL single last_tag got=%h exp=1", last_tag); end
    total++; if (rd_cnt !== 17) begin bad++; $display("FAIL single reads got=%0d exp=17", rd_cnt); end
  endtask

  task automatic test_multi();
    do_reset();
    check_en = 1'b1;
    push_evt(32'h0040_0001, 0, 16);
    push_evt(32'h0000_0002, 0, 0);
    push_evt(32'h0020_0003, 17, 8);
    wait_done("multi");
    total++; if (evt_cnt !== 32'd3) begin bad++; $display("FAIL multi evt_cnt got=%0d exp=3", evt_cnt); end
    total++; if (word_err_cnt !== 16'd0 || tag_err_cnt !== 16'd0) begin
      bad++; $display("FAIL multi errs got=%0d/%0d exp=0/0", word_err_cnt, tag_err_cnt); end
    total++; if (err_sticky !== 1'b0 || last_tag !== 20'd3) begin
      bad++; $display("FAIL multi sticky/tag got=%b/%h exp=0/3", err_sticky, last_tag); end
  endtask

  task automatic test_alt();
    logic [31:0] w [8];
    w = '{32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA,
          32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5555};
    do_reset();
    pattern_type = 1'b1;
    check_en = 1'b1;
    q.push_back(32'h0020_0001);
    for (int i = 0; i < 8; i++) q.push_back(w[i]);
    wait_done("alt");
    total++; if (word_err_cnt !== 16'd1) begin bad++; $display("FAIL alt word_err got=%0d exp=1", word_err_cnt); end
    total++; if (first_err_got !== 32'h5555_5555) begin bad++; $display("FAIL alt first_got got=%h exp=55555555", first_err_got); end
    total++; if (first_err_exp !== 32'hAAAA_AAAA) begin bad++; $display("FAIL alt first_exp got=%h exp=aaaaaaaa", first_err_exp); end
    total++; if (err_sticky !== 1'b1 || evt_cnt !== 32'd1) begin
      bad++; $display("FAIL alt sticky/evt got=%b/%0d exp=1/1", err_sticky, evt_cnt); end
  endtask

  task automatic test_tags();
    do_reset();
    check_en = 1'b1;
    push_evt(32'h0000_0005, 0, 0);
    push_evt(32'h0000_0007, 0, 0);
    push_evt(32'h0030_0008, 2, 12);
    wait_done("tags");
    total++; if (tag_err_cnt !== 16'd2) begin bad++; $display("FAIL tags tag_err got=%0d exp=2", tag_err_cnt); end
    total++; if (word_err_cnt !== 16'd0) begin bad++; $display("FAIL tags word_err got=%0d exp=0", word_err_cnt); end
    total++; if (err_sticky !== 1'b1 || last_tag !== 20'd8 || evt_cnt !== 32'd3) begin
      bad++; $display("FAIL tags sticky/tag/evt got=%b/%h/%0d exp=1/8/3", err_sticky, last_tag, evt_cnt); end
  endtask

  task automatic test_spill();
    do_reset();
    check_en = 1'b1;
    // Partial event 0,1,2 then a spill that keeps the counter (next expected is 3).
    push_evt(32'h0020_0001, 0, 3);
    repeat (20) @(negedge fifoclk);
    total++; if (busy !== 1'b1 || q.size() != 0) begin
      bad++; $display("FAIL spill_hold busy got=%b q=%0d exp=1/0", busy, q.size()); end
    @(posedge fifoclk); #2;
    haltrun_en = 1'b1; newspill_reset = 1'b1;
    @(posedge fifoclk); #2;
    newspill_reset = 1'b0;
    @(negedge fifoclk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL spill_idle busy got=%b exp=0", busy); end
    push_evt(32'h0020_0007, 3, 8);
    wait_done("spill_halt");
    total++; if (word_err_cnt !== 16'd0 || evt_cnt !== 32'd1 || tag_err_cnt !== 16'd0) begin
      bad++; $display("FAIL spill_halt werr/evt/terr got=%0d/%0d/%0d exp=0/1/0", word_err_cnt, evt_cnt, tag_err_cnt); end
    // Partial event then a spill that clears the counter: payload restarts at 0.
    @(posedge fifoclk); #2;
    push_evt(32'h0020_0008, 11, 2);
    repeat (20) @(negedge fifoclk);
    @(posedge fifoclk); #2;
    haltrun_en = 1'b0; newspill_reset = 1'b1;
    @(posedge fifoclk); #2;
    newspill_reset = 1'b0;
    push_evt(32'h0020_000A, 0, 8);
    wait_done("spill_clear");
    total++; if (word_err_cnt !== 16'd0 || evt_cnt !== 32'd2 || tag_err_cnt !== 16'd0) begin
      bad++; $display("FAIL spill_clear werr/evt/terr got=%0d/%0d/%0d exp=0/2/0", word_err_cnt, evt_cnt, tag_err_cnt); end
    total++; if (last_tag !== 20'h0000A) begin bad++; $display("FAIL spill_clear last_tag got=%h exp=a", last_tag); end
  endtask

  task automatic test_throttle();
    do_reset();
    stall_mode = 1'b1;
    check_en = 1'b1;
    push_evt(32'h0040_0001, 0, 16);
    // check_en dropping mid-event must not abort the event.
    repeat (12) @(negedge fifoclk);
    check_en = 1'b0;
    wait_done("throttle");
    total++; if (evt_cnt !== 32'd1 || word_err_cnt !== 16'd0) begin
      bad++; $display("FAIL throttle evt/werr got=%0d/%0d exp=1/0", evt_cnt, word_err_cnt); end
    total++; if (rd_cnt !== 17 || last_tag !== 20'd1) begin
      bad++; $display("FAIL throttle reads/tag got=%0d/%h exp=17/1", rd_cnt, last_tag); end
    total++; if (re_viol !== 0) begin bad++; $display("FAIL re_while_empty got=%0d exp=0", re_viol); end
    stall_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_alt();
    test_tags();
    test_spill();
    test_throttle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
